// File: rtl/seven_seg_scanner_if.sv
// Bundle between a datapath and the multiplexed 7-segment scanner: display
// request signals toward the scanner, board pin drives back out.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic [3:0]              bright;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output value, dp_in, load, blank_lz, bright,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  value, dp_in, load, blank_lz, bright,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Registered multiplexed N-digit hex display driver with frame-synchronous
// loading, leading-zero blanking, per-digit decimal points and 16-level PWM.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int PW = $clog2(DIV);
    localparam int CW = PW + 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT16 = DIV / 16;
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val, pend_val;
    logic [NUM_DIGITS-1:0]   shadow_dp, pend_dp;
    logic                    pend_flag;

    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    fd_q;

    logic                    slot_tick, frame_wrap;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lz_run;
    logic [CW-1:0]           on_limit;
    logic                    pwm_on;
    logic [NUM_DIGITS-1:0]   onehot;

    // Active-high glyphs {g,f,e,d,c,b,a}; b and d are lowercase.
    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b0111111;
            4'h1: decode = 7'b0000110;
            4'h2: decode = 7'b1011011;
            4'h3: decode = 7'b1001111;
            4'h4: decode = 7'b1100110;
            4'h5: decode = 7'b1101101;
            4'h6: decode = 7'b1111101;
            4'h7: decode = 7'b0000111;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1101111;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b1111100;
            4'hC: decode = 7'b0111001;
            4'hD: decode = 7'b1011110;
            4'hE: decode = 7'b1111001;
            default: decode = 7'b1110001;
        endcase
    endfunction

    assign slot_tick  = (pcnt == PCNT_MAX);
    assign frame_wrap = slot_tick && (idx == IDX_MAX);
    assign cur_digit  = shadow_val[{idx, 2'b00} +: 4];
    assign on_limit   = CW'(bus.bright + 5'd1) * CW'(SLOT16);
    assign pwm_on     = ({1'b0, pcnt} < on_limit);
    assign onehot     = NUM_DIGITS'(1) << idx;

    // A digit is blanked while every digit from the top down to it is zero.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // through this block leaves a value held, which would infer a latch.
        lz_run     = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run        = lz_run & (shadow_val[4*i +: 4] == 4'h0);
            blank_mask[i] = lz_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_flag  <= 1'b0;
            an_q       <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q      <= {7{ACTIVE_LOW}};
            dp_q       <= ACTIVE_LOW;
            fd_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register here sample
            // the pre-edge state, so ordering inside the block is irrelevant.
            pcnt <= slot_tick ? '0 : pcnt + 1'b1;
            if (slot_tick)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;

            // A load landing on the wrap bypasses the pending stage entirely.
            if (frame_wrap) begin
                if (bus.load) begin
                    shadow_val <= bus.value;
                    shadow_dp  <= bus.dp_in;
                end else if (pend_flag) begin
                    shadow_val <= pend_val;
                    shadow_dp  <= pend_dp;
                end
                pend_flag <= 1'b0;
            end else if (bus.load) begin
                pend_val  <= bus.value;
                pend_dp   <= bus.dp_in;
                pend_flag <= 1'b1;
            end

            an_q  <= (pwm_on ? onehot : '0) ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_q <= ((bus.blank_lz && blank_mask[idx]) ? 7'h00 : decode(cur_digit))
                     ^ {7{ACTIVE_LOW}};
            dp_q  <= shadow_dp[idx] ^ ACTIVE_LOW;
            fd_q  <= frame_wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a frame-level reference model
// predicts every registered pin value each cycle under directed and random stimulus.
module tb_seven_seg_scanner;
    localparam int N     = 4;
    localparam int DIV   = 16;
    localparam int FRAME = N * DIV;
    localparam logic [12:0] RST_OUT = {4'b1111, 7'b1111111, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS(N),
        .DIV       (DIV),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [12:0] dut_out;
    assign dut_out = {bus.an, bus.seg, bus.dp, bus.frame_done};

    logic [6:0] glyph [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    // Reference model: the image shown during frame f is the last load made
    // during frame f-1 (a load on the final cycle of f-1 included), else unchanged.
    int          t = 0;
    logic [15:0] sh_val = '0, nx_val = '0;
    logic [3:0]  sh_dp = '0, nx_dp = '0;
    bit          nx_valid = 0;
    logic [12:0] exp_out = RST_OUT;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; sh_val = '0; sh_dp = '0; nx_valid = 0;
            exp_out = RST_OUT;
        end else begin
            int d, pc, hi;
            bit blanked, a_on;
            logic [3:0] e_an;
            logic [6:0] seg_h;
            d  = (t / DIV) % N;
            pc = t % DIV;
            hi = 0;
            for (int i = 0; i < N; i++)
                if (sh_val[4*i +: 4] != 4'h0) hi = i;
            blanked = bus.blank_lz && (d > hi);
            seg_h   = blanked ? 7'h00 : glyph[sh_val[4*d +: 4]];
            a_on    = pc < (int'(bus.bright) + 1) * (DIV / 16);
            e_an    = a_on ? ~(4'b0001 << d) : 4'b1111;
            exp_out = {e_an, ~seg_h, ~sh_dp[d], (t % FRAME) == FRAME - 1};
            if (bus.load) begin
                nx_val = bus.value; nx_dp = bus.dp_in; nx_valid = 1;
            end
            if ((t % FRAME) == FRAME - 1 && nx_valid) begin
                sh_val = nx_val; sh_dp = nx_dp; nx_valid = 0;
            end
            t++;
        end
    end

    // Advance (unchecked) to the negedge inside state cycle with t % FRAME == ph.
    task automatic advance_to(input int ph);
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if ((t % FRAME) == ph) return;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] p);
        bus.value = v; bus.dp_in = p; bus.load = 1'b1;
        @(negedge clk);
        total++;
        if (dut_out !== exp_out) begin
            bad++;
            $display("FAIL load_cycle: got %b expected %b", dut_out, exp_out);
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            total++;
            if (dut_out !== RST_OUT) begin
                bad++;
                $display("FAIL reset_value: got %b expected %b", dut_out, RST_OUT);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int fd_count = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            total++;
            fd_count += int'(bus.frame_done);
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL idle t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
        end
        total++;
        if (fd_count !== 3) begin
            bad++;
            $display("FAIL idle_frame_done_count: got %0d expected 3", fd_count);
        end
    endtask

    task automatic test_load_sync();
        logic [6:0] want [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
        advance_to(20);
        pulse_load(16'h1A3F, 4'b0000);
        repeat (2 * FRAME) begin
            @(negedge clk);
            total++;
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL load_sync t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
        end
        for (int d = 0; d < N; d++) begin
            advance_to(d * DIV + 1);
            total++;
            if (bus.seg !== want[d]) begin
                bad++;
                $display("FAIL load_sync_digit%0d: got %b expected %b", d, bus.seg, want[d]);
            end
        end
    endtask

    task automatic test_load_at_wrap();
        advance_to(10);
        pulse_load(16'h4321, 4'b0000);
        advance_to(FRAME - 1);
        pulse_load(16'h8888, 4'b0000);
        repeat (3 * FRAME) begin
            @(negedge clk);
            total++;
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL load_at_wrap t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
            if (bus.seg !== 7'b0000000) begin
                bad++;
                $display("FAIL load_at_wrap_glyph t=%0d: got %b expected 0000000", t, bus.seg);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] want [4] = '{{7'b1000000, 1'b1}, {7'b0010010, 1'b1},
                                 {7'b1111111, 1'b1}, {7'b1111111, 1'b0}};
        bus.blank_lz = 1'b1;
        advance_to(5);
        pulse_load(16'h0050, 4'b1000);
        repeat (2 * FRAME) begin
            @(negedge clk);
            total++;
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL blank t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
        end
        for (int d = 0; d < N; d++) begin
            advance_to(d * DIV + 1);
            total++;
            if ({bus.seg, bus.dp} !== want[d]) begin
                bad++;
                $display("FAIL blank_digit%0d: got %b expected %b", d, {bus.seg, bus.dp}, want[d]);
            end
        end
        pulse_load(16'h0000, 4'b0000);
        repeat (2 * FRAME) begin
            @(negedge clk);
            total++;
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL blank_zero t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_brightness();
        int levels [3] = '{3, 15, 0};
        for (int b = 0; b < 3; b++) begin
            int on_cycles = 0;
            advance_to(0);
            bus.bright = 4'(levels[b]);
            repeat (FRAME) begin
                @(negedge clk);
                total++;
                on_cycles += int'(bus.an != 4'b1111);
                if (dut_out !== exp_out) begin
                    bad++;
                    $display("FAIL bright%0d t=%0d: got %b expected %b", levels[b], t, dut_out, exp_out);
                end
            end
            total++;
            if (on_cycles !== (levels[b] + 1) * N) begin
                bad++;
                $display("FAIL bright%0d_duty: got %0d expected %0d", levels[b], on_cycles, (levels[b] + 1) * N);
            end
        end
        bus.bright = 4'd15;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int gap = $urandom_range(0, 90);
            repeat (gap) begin
                @(negedge clk);
                total++;
                if (dut_out !== exp_out) begin
                    bad++;
                    $display("FAIL random t=%0d: got %b expected %b", t, dut_out, exp_out);
                end
            end
            bus.blank_lz = 1'($urandom_range(0, 1));
            bus.bright   = 4'($urandom_range(0, 15));
            pulse_load(($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                       4'($urandom));
        end
        repeat (2 * FRAME) begin
            @(negedge clk);
            total++;
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL random_tail t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
        end
        bus.blank_lz = 1'b0;
        bus.bright   = 4'd15;
    endtask

    task automatic test_reset_mid();
        advance_to(30);
        pulse_load(16'hBEEF, 4'b0101);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dut_out !== RST_OUT) begin
            bad++;
            $display("FAIL reset_async: got %b expected %b", dut_out, RST_OUT);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FRAME) begin
            @(negedge clk);
            total++;
            if (dut_out !== exp_out) begin
                bad++;
                $display("FAIL reset_mid t=%0d: got %b expected %b", t, dut_out, exp_out);
            end
            if (bus.an != 4'b1111 && bus.seg !== 7'b1000000) begin
                bad++;
                $display("FAIL reset_mid_glyph t=%0d: got %b expected 1000000", t, bus.seg);
            end
        end
    endtask

    initial begin
        bus.value    = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.bright   = 4'd15;
        test_reset();
        test_idle();
        test_load_sync();
        test_load_at_wrap();
        test_blanking();
        test_brightness();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
